// File: rtl/sync_fifo_fwft_if.sv
// Stream bundle for sync_fifo_fwft: producer-side write stream, consumer-side read stream, occupancy.
// The FIFO connects through the slave modport; a producer/consumer pair (or bench) uses master.
// No logic lives here; handshakes are valid/ready on both streams.
interface sync_fifo_fwft_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [ADDR_WIDTH:0]   level;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, level
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, level
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: pointer control plus registered-read dual-port RAM as output stage.
// Latency: push presented in cycle C is visible on m_valid/m_data in cycle C+2; 1 push + 1 pop per cycle sustained.
// Backpressure: s_ready drops only when the RAM holds 2^ADDR_WIDTH entries (capacity 2^ADDR_WIDTH+1); no pop-to-push bypass.
// Optional occupancy counter on bus.level enabled by macro SYNC_FIFO_FWFT_LEVEL_EN (tied to 0 otherwise).

// Simple dual-port RAM, one clock, registered read port that holds when re=0.
module simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter bit ENABLE_BYPASS = 1'b0
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; optional write-to-read forwarding on address collision.
  always_ff @(posedge clk) begin
    if (re) begin
      if (ENABLE_BYPASS && we && (waddr == raddr)) dout <= wdata;
      else                                         dout <= mem[raddr];
    end
  end
endmodule

module sync_fifo_fwft #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  sync_fifo_fwft_if.slave      bus
);
  localparam logic [ADDR_WIDTH:0] RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = 1;

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  out_valid;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  push;
  logic                  pop;
  logic                  we;
  logic                  re;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;

  // Wrap bit in the MSB makes the plain difference a correct RAM occupancy (0..2^ADDR_WIDTH).
  assign ram_cnt     = wr_ptr - rd_ptr;
  assign bus.s_ready = !rst && (ram_cnt != RAM_DEPTH);
  assign push        = bus.s_valid && bus.s_ready;
  assign pop         = out_valid && bus.m_ready;

  // Prefetch whenever the output stage is empty or being consumed this cycle.
  assign re    = !rst && (ram_cnt != '0) && (!out_valid || pop);
  assign we    = push;
  assign waddr = wr_ptr[ADDR_WIDTH-1:0];
  assign raddr = rd_ptr[ADDR_WIDTH-1:0];

  assign bus.m_valid = out_valid;

  simple_dpram_sclk #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .ENABLE_BYPASS (1'b0)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.s_data),
    .re    (re),
    .raddr (raddr),
    .dout  (bus.m_data)
  );

  // Pointer and output-stage state; reset discards all contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (re)   rd_ptr <= rd_ptr + PTR_ONE;
      if (re)       out_valid <= 1'b1;
      else if (pop) out_valid <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_LEVEL_EN
  logic [ADDR_WIDTH:0] level_q;

  // Occupancy counter including the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
    end else if (push && !pop) begin
      level_q <= level_q + PTR_ONE;
    end else if (pop && !push) begin
      level_q <= level_q - PTR_ONE;
    end
  end

  assign bus.level = level_q;

  a_level_consistent: assert property (@(posedge clk) disable iff (rst)
    level_q == ram_cnt + (ADDR_WIDTH+1)'(out_valid));
`else
  assign bus.level = '0;
`endif

  // The RAM has no collision forwarding, so a same-slot read and write must never coincide.
  a_no_same_addr: assert property (@(posedge clk) disable iff (rst)
    !(re && we && (raddr == waddr)));

  // Producer must hold its payload while stalled.
  a_hold_data: assert property (@(posedge clk) disable iff (rst)
    (bus.s_valid && !bus.s_ready) |=> (!bus.s_valid || $stable(bus.s_data)));
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft with ADDR_WIDTH=2 (capacity 5), 8-bit payload.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_sync_fifo_fwft;
  localparam int AW = 2;
  localparam int DW = 8;
`ifdef SYNC_FIFO_FWFT_LEVEL_EN
  localparam bit LEVEL_ON = 1'b1;
`else
  localparam bit LEVEL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_fwft_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sync_fifo_fwft #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_level(input int n);
    return LEVEL_ON ? 32'(n) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] next_val;
  int            pops;
  int            sent;
  int            got;
  bit            hold;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_s_ready_after", 32'(bus.s_ready), 1);

    // Single push of 0xA5, visible two cycles later, then popped.
    tick();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA5;
    @(negedge clk);
    chk("s1_ready", 32'(bus.s_ready), 1);
    chk("s1_level0", 32'(bus.level), exp_level(0));
    tick();
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("s1_mvalid_c1", 32'(bus.m_valid), 0);
    chk("s1_level1", 32'(bus.level), exp_level(1));
    tick();
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("s1_mvalid_c2", 32'(bus.m_valid), 1);
    chk("s1_mdata", 32'(bus.m_data), 32'hA5);
    chk("s1_level2", 32'(bus.level), exp_level(1));
    tick();
    bus.m_ready = 1'b0;
    @(negedge clk);
    chk("s1_mvalid_c3", 32'(bus.m_valid), 0);
    chk("s1_level3", 32'(bus.level), exp_level(0));
    tick();

    // Fill: 1..5 accepted, 6 held off; then drain 1..5 with no gaps.
    for (int v = 1; v <= 6; v++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(v);
      @(negedge clk);
      chk("s2_ready", 32'(bus.s_ready), (v <= 5) ? 32'd1 : 32'd0);
      tick();
    end
    @(negedge clk);
    chk("s2_full_ready", 32'(bus.s_ready), 0);
    chk("s2_full_level", 32'(bus.level), exp_level(5));
    chk("s2_head_valid", 32'(bus.m_valid), 1);
    chk("s2_head_data", 32'(bus.m_data), 1);
    tick();
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("s2_drain_valid", 32'(bus.m_valid), 1);
      chk("s2_drain_data", 32'(bus.m_data), 32'(k));
      chk("s2_drain_level", 32'(bus.level), exp_level(6 - k));
      tick();
    end
    @(negedge clk);
    chk("s2_empty_valid", 32'(bus.m_valid), 0);
    chk("s2_empty_level", 32'(bus.level), exp_level(0));
    tick();

    // Streaming 20 values with the consumer always ready.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 24; c++) begin
      bus.s_valid = (sent < 20);
      bus.s_data  = 8'(8'h40 + sent);
      bus.m_ready = 1'b1;
      @(negedge clk);
      if (c < 20) begin
        chk("s3_ready", 32'(bus.s_ready), 1);
        chk("s3_level", 32'(bus.level), exp_level((c < 2) ? c : 2));
      end
      if (c >= 2 && c < 22) chk("s3_mvalid", 32'(bus.m_valid), 1);
      if (bus.m_valid && bus.m_ready) begin
        chk("s3_data", 32'(bus.m_data), 32'(8'h40 + got));
        got++;
      end
      if (bus.s_valid && bus.s_ready) sent++;
      tick();
    end
    chk("s3_count", 32'(got), 20);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;

    // Mixed valid/ready with a queue scoreboard across many pointer wraps.
    q.delete();
    next_val = 8'h00;
    pops     = 0;
    hold     = 1'b0;
    for (int c = 0; c < 20000 && pops < 1000; c++) begin
      if (!hold) begin
        bus.s_valid = 1'($urandom % 2);
        bus.s_data  = next_val;
      end
      bus.m_ready = 1'($urandom % 2);
      @(negedge clk);
      chk("rnd_ready", 32'(bus.s_ready), (q.size() < 5) ? 32'd1 : 32'd0);
      chk("rnd_level", 32'(bus.level), exp_level(q.size()));
      if (q.size() == 0) chk("rnd_empty_valid", 32'(bus.m_valid), 0);
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) begin
          chk("rnd_pop_nonempty", 32'(q.size()), 1);
        end else begin
          chk("rnd_data", 32'(bus.m_data), 32'(q[0]));
          void'(q.pop_front());
        end
        pops++;
      end
      if (bus.s_valid && bus.s_ready) begin
        q.push_back(bus.s_data);
        next_val = next_val + 8'd1;
      end
      hold = bus.s_valid && !bus.s_ready;
      tick();
    end
    chk("rnd_budget", 32'(pops), 1000);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.m_valid && q.size() != 0) begin
        chk("rnd_drain_data", 32'(bus.m_data), 32'(q[0]));
        void'(q.pop_front());
      end
      tick();
    end
    @(negedge clk);
    chk("rnd_drained", 32'(q.size()), 0);
    chk("rnd_drained_valid", 32'(bus.m_valid), 0);
    tick();
    bus.m_ready = 1'b0;

    // Reset while full, with push and pop requested in the reset cycle.
    for (int v = 0; v < 5; v++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(8'h10 + v);
      tick();
    end
    rst = 1'b1;
    bus.s_data  = 8'h99;
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("s5_rst_ready", 32'(bus.s_ready), 0);
    tick();
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    chk("s5_mvalid", 32'(bus.m_valid), 0);
    chk("s5_level", 32'(bus.level), 0);
    chk("s5_ready", 32'(bus.s_ready), 1);
    tick();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h3C;
    tick();
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("s5_c1_mvalid", 32'(bus.m_valid), 0);
    tick();
    @(negedge clk);
    chk("s5_c2_mvalid", 32'(bus.m_valid), 1);
    chk("s5_c2_mdata", 32'(bus.m_data), 32'h3C);
    chk("s5_c2_level", 32'(bus.level), exp_level(1));
    tick();
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    @(negedge clk);
    chk("s5_end_mvalid", 32'(bus.m_valid), 0);
    chk("s5_end_level", 32'(bus.level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
